// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single memory port (MAR/MDR/memWE out, mem_out back) between
// two requesters.
//   requester 0 : CPU, fixed priority
//   requester 1 : DMA / video-fill engine, with a starvation guard
//
// Arbitration is combinational and issues at most one transfer per cycle.
// The memory has a 1-cycle registered read. The owner of each read grant is
// recorded so that its rvalid pulses in the following cycle.
//
// Ports
//   clk              system clock; all state changes on the rising edge
//   reset            asynchronous, active-low reset
//   req0/we0/addr0/wdata0   CPU request; held until gnt0
//   gnt0             CPU request accepted this cycle
//   rvalid0/rdata0   CPU read return; rdata0 is meaningful only with rvalid0
//   req1/we1/addr1/wdata1   DMA request; same semantics as the CPU port
//   gnt1             DMA request accepted this cycle
//   rvalid1/rdata1   DMA read return
//   MAR/MDR/memWE    memory address, write data and write enable
//   mem_out          memory read data, valid 1 cycle after MAR is presented
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4      // legal range 1..15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] MAR,
    output logic [DATA_W-1:0] MDR,
    output logic              memWE,
    input  logic [DATA_W-1:0] mem_out
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       starved;
    logic       rd_vld;     // a read was issued last cycle
    logic       rd_owner;   // 0 = CPU, 1 = DMA

    assign starved = (wait_cnt == WAIT_LIMIT);

    // -----------------------------------------------------------------------
    // Grant decision. While reset is held low, both grants are suppressed.
    // The only way the CPU loses a contested cycle is when the DMA has been
    // blocked for MAX_WAIT cycles in a row.
    // -----------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (req0 && !(req1 && starved))
                gnt0 = 1'b1;
            else if (req1)
                gnt1 = 1'b1;
        end
    end

    // When there is no grant, the mux defaults to the CPU side. This keeps
    // MAR stable for the common CPU-only case.
    assign MAR   = gnt1 ? addr1  : addr0;
    assign MDR   = gnt1 ? wdata1 : wdata0;
    assign memWE = (gnt0 & we0) | (gnt1 & we1);

    // -----------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles in which the DMA is
    // requesting but not granted. It saturates at MAX_WAIT, so the guard
    // stays armed until the DMA actually wins.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (!req1 || gnt1)
            wait_cnt <= '0;
        else if (wait_cnt != WAIT_LIMIT)
            wait_cnt <= wait_cnt + 4'd1;
    end

    // -----------------------------------------------------------------------
    // Read-return tag. At most one grant exists per cycle, so a single
    // valid/owner pair is enough to track the one read in flight. A new
    // grant may issue in the same cycle that an earlier read returns.
    // Asynchronous reset drops any pending return.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld   <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_vld <= (gnt0 & ~we0) | (gnt1 & ~we1);
            if ((gnt0 & ~we0) | (gnt1 & ~we1))
                rd_owner <= gnt1;
        end
    end

    assign rvalid0 = rd_vld & ~rd_owner;
    assign rvalid1 = rd_vld &  rd_owner;

    // Both return buses carry the raw memory output; rvalid qualifies them.
    assign rdata0 = mem_out;
    assign rdata1 = mem_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// A behavioural block RAM with a 1-cycle registered read sits behind the
// arbiter. Inputs change on the falling edge. Outputs are sampled 1 time
// unit later, which is well clear of the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1, memWE;
    logic [DATA_W-1:0] rdata0, rdata1, MDR, mem_out;
    logic [ADDR_W-1:0] MAR;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [0:65535];

    always #5 clk = ~clk;

    // Registered-read RAM with read-first behaviour on the same address.
    always @(posedge clk) begin
        if (memWE) mem[MAR] <= MDR;
        mem_out <= mem[MAR];
    end

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .MAR(MAR), .MDR(MDR), .memWE(memWE), .mem_out(mem_out)
    );

    task automatic next_cycle;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle_inputs();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        next_cycle(); next_cycle();
        #1;
        checks++;
        if ({gnt0, gnt1, memWE} !== 3'b000) begin
            errors++;
            $display("FAIL reset_grants: got gnt0/gnt1/memWE=%b want 000", {gnt0, gnt1, memWE});
        end
        checks++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rvalid: got %b want 00", {rvalid0, rvalid1});
        end
        next_cycle();
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_gnt: got gnt0/gnt1=%b want 10", {gnt0, gnt1});
        end
        idle_inputs();
        next_cycle(); next_cycle();
    endtask

    task automatic test_idle;
        idle_inputs();
        addr0 = 16'h0ABC; wdata0 = 16'h1357; addr1 = 16'h0DEF;
        #1;
        checks++;
        if ({gnt0, gnt1, memWE} !== 3'b000 || MAR !== 16'h0ABC || MDR !== 16'h1357) begin
            errors++;
            $display("FAIL idle_mux: got g=%b%b we=%b MAR=%h MDR=%h want 00 0 0abc 1357",
                     gnt0, gnt1, memWE, MAR, MDR);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_cpu_write_read;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; wdata0 = 16'hBEEF;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || memWE !== 1'b1 || MAR !== 16'h0005 || MDR !== 16'hBEEF) begin
            errors++;
            $display("FAIL cpu_write: got gnt0=%b memWE=%b MAR=%h MDR=%h want 1 1 0005 beef",
                     gnt0, memWE, MAR, MDR);
        end
        next_cycle();
        we0 = 1'b0;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || memWE !== 1'b0 || {rvalid0, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL cpu_read_issue: got gnt0=%b memWE=%b rv=%b%b want 1 0 00",
                     gnt0, memWE, rvalid0, rvalid1);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 16'hBEEF || rvalid1 !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_return: got rvalid0=%b rdata0=%h rvalid1=%b want 1 beef 0",
                     rvalid0, rdata0, rvalid1);
        end
        next_cycle();
        #1;
        checks++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL cpu_read_one_shot: got %b want 00", {rvalid0, rvalid1});
        end
    endtask

    task automatic test_starvation;
        int bad;
        bad = 0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0100; wdata0 = 16'h0001;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0200; wdata1 = 16'h0002;
        for (int i = 0; i < 10; i++) begin
            logic exp1;
            exp1 = ((i % 5) == 4);
            #1;
            checks++;
            if (gnt0 !== !exp1 || gnt1 !== exp1 || MAR !== (exp1 ? 16'h0200 : 16'h0100)) begin
                errors++;
                $display("FAIL starve_cycle%0d: got gnt0=%b gnt1=%b MAR=%h want %b %b %h",
                         i, gnt0, gnt1, MAR, !exp1, exp1, exp1 ? 16'h0200 : 16'h0100);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_alternating_reads;
        mem[16'h0010] = 16'h1111;
        mem[16'h1010] = 16'h2222;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || MAR !== 16'h0010) begin
            errors++;
            $display("FAIL alt_issue0: got gnt0=%b MAR=%h want 1 0010", gnt0, MAR);
        end
        next_cycle();
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 16'h1010;
        #1;
        checks++;
        if (gnt1 !== 1'b1 || MAR !== 16'h1010 || rvalid0 !== 1'b1 || rdata0 !== 16'h1111 || rvalid1 !== 1'b0) begin
            errors++;
            $display("FAIL alt_ret0: got gnt1=%b MAR=%h rvalid0=%b rdata0=%h rvalid1=%b want 1 1010 1 1111 0",
                     gnt1, MAR, rvalid0, rdata0, rvalid1);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 16'h2222 || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL alt_ret1: got rvalid1=%b rdata1=%h rvalid0=%b want 1 2222 0",
                     rvalid1, rdata1, rvalid0);
        end
        next_cycle();
        #1;
        checks++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL alt_quiet: got %b want 00", {rvalid0, rvalid1});
        end
    endtask

    task automatic test_dma_write;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h1234; wdata1 = 16'hCAFE;
        addr0 = 16'h0077;
        #1;
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || memWE !== 1'b1 || MAR !== 16'h1234 || MDR !== 16'hCAFE) begin
            errors++;
            $display("FAIL dma_write: got gnt1=%b gnt0=%b memWE=%b MAR=%h MDR=%h want 1 0 1 1234 cafe",
                     gnt1, gnt0, memWE, MAR, MDR);
        end
        next_cycle();
        // A DMA that keeps winning alone never builds up wait_cnt. The first
        // contested cycle after that must therefore still go to the CPU.
        req0 = 1'b1; we0 = 1'b1;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL dma_wait_clear: got gnt0/gnt1=%b want 10", {gnt0, gnt1});
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL dma_write_no_rvalid: got %b%b want 00", rvalid0, rvalid1);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_read;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (rvalid0 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pending: got rvalid0=%b want 1", rvalid0);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drop: got rvalid0=%b rvalid1=%b want 0 0", rvalid0, rvalid1);
        end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        #1;
        checks++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_after: got %b want 00", {rvalid0, rvalid1});
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_idle();
        test_cpu_write_read();
        test_starvation();
        test_alternating_reads();
        test_dma_write();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single system-RAM/video-memory port (MAR/MDR/memWE in, mem_out back) between two requesters.
- Requester 0 is the CPU and has priority. Requester 1 is a DMA/video-fill engine.
- Fixed priority with a starvation guard; one transfer per cycle; owner-tagged read-return pipeline matching the block RAM's 1-cycle registered read.
- Sits between the CPU/DMA and the memory block, driving its MAR/MDR/memWE inputs.

Parameters:
- ADDR_W, 16, address width of requester and memory address buses.
- DATA_W, 16, data width.
- MAX_WAIT, 4, cycles requester 1 may be blocked while requesting before it is forced to win (range 1..15).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- req0  input  1  CPU request, held until gnt0
- we0  input  1  CPU write enable (1 = write, 0 = read)
- addr0  input  ADDR_W  CPU address
- wdata0  input  DATA_W  CPU write data
- gnt0  output  1  CPU request accepted this cycle
- rvalid0  output  1  CPU read data valid
- rdata0  output  DATA_W  CPU read data
- req1, we1, addr1, wdata1  input  1/1/ADDR_W/DATA_W  DMA request, same semantics
- gnt1  output  1  DMA request accepted this cycle
- rvalid1  output  1  DMA read data valid
- rdata1  output  DATA_W  DMA read data
- MAR  output  ADDR_W  memory address
- MDR  output  DATA_W  memory write data
- memWE  output  1  memory write enable
- mem_out  input  DATA_W  memory read data, valid 1 cycle after MAR presented

Behaviour:
- Reset (reset=0, async):
  - wait_cnt=0, rvalid0=rvalid1=0, rd_owner=0.
  - gnt0=gnt1=0 and memWE=0 while reset is low, regardless of req inputs.
- Grant decision is combinational each cycle:
  - Only req0: gnt0=1.
  - Only req1: gnt1=1.
  - Both, wait_cnt<MAX_WAIT: gnt0=1.
  - Both, wait_cnt==MAX_WAIT: gnt1=1.
  - Neither: no grant.
  - Never both grants in one cycle.
- Port mux:
  - MAR/MDR take addr/wdata of the granted requester.
  - With no grant, MAR/MDR hold requester 0's addr0/wdata0.
  - memWE = (gnt0&we0)|(gnt1&we1).
- Transfers: one per grant, no bursts. A requester holding req high gets back-to-back grants if it keeps winning.
- wait_cnt (4-bit, registered):
  - req1&~gnt1: increment, saturate at MAX_WAIT.
  - gnt1: clear to 0.
  - ~req1: clear to 0.
- Read return:
  - A read grant (gnt&~we) at cycle N registers the owner.
  - At N+1: rvalid_owner=1 for exactly one cycle; rdata_owner=mem_out.
  - Back-to-back reads from alternating requesters return in grant order, one per cycle.
- Writes: gnt is the completion acknowledge; no rvalid is generated.
- rdata0/rdata1 are both wired to mem_out and meaningful only when their rvalid is high.
- Simultaneous read return (from N-1) and new grant (at N) is legal: return and issue are independent.
- Reset asserted mid-read: the pending rvalid is dropped (cleared asynchronously) and is not produced after reset releases.
- Address decode (RAM vs. video region) is not done here; full MAR is forwarded.

Test Plan:
- Reset low, req0=req1=1 -> gnt0=gnt1=0, memWE=0, rvalid0=rvalid1=0. After release, first cycle gnt0=1.
- req0 write addr0=0x0005, wdata0=0xBEEF, then read 0x0005 -> write cycle: memWE=1, MAR=0x0005, MDR=0xBEEF. Read: gnt0 at N; at N+1 rvalid0=1, rdata0=0xBEEF, rvalid1=0.
- req0 and req1 held continuously, MAX_WAIT=4 -> pattern gnt0×4, gnt1×1, repeating. wait_cnt resets to 0 after each gnt1.
- Alternating reads: cycle N read by req0 at 0x0010, cycle N+1 read by req1 at 0x1010 -> rvalid0 at N+1, rvalid1 at N+2, each high exactly one cycle with the matching mem_out.
- req1-only write to 0x1234 while req0=0 -> gnt1 same cycle, memWE=1, MAR=0x1234, wait_cnt stays 0.
- Read granted at N, reset pulsed low mid-cycle N+1 -> rvalid0 forced 0 immediately; no rvalid after release.
